// File: rtl/regfile_dual_rd.sv
// Register file: one write port, two registered read ports, optional write-to-read
// bypass, and a hardware clear-all sweep that zeroes every register in turn.
module regfile_dual_rd #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel0,
    input  logic [AW-1:0]    rsel1,
    input  logic             init,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam int            AW1        = AW + 1;
    localparam logic [AW:0]   DEPTH_C    = AW1'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR_C = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  q0_q, q0_d;
    logic [WIDTH-1:0]  q1_q, q1_d;
    logic              busy_q, busy_d;

    logic              user_wr_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic [WIDTH-1:0]  wr_data_s;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_C);
    endfunction

    // Out-of-range reads return zero; a matching active write is forwarded when bypass is on.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0]    addr,
                                                   input logic             wen,
                                                   input logic [AW-1:0]    waddr,
                                                   input logic [WIDTH-1:0] wdata);
        logic [WIDTH-1:0] result;
        result = {WIDTH{1'b0}};
        if (!in_range(addr)) begin
            result = {WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wen && (waddr == addr)) begin
            result = wdata;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr == AW'(i)) begin
                    result = mem_q[i];
                end else begin
                    result = result;
                end
            end
        end
        return result;
    endfunction

    // Select the single active write for this cycle: accepted user write, else sweep clear.
    always_comb begin
        user_wr_s = en && (state_q == ST_IDLE) && !init && in_range(wsel);
        wr_en_s   = 1'b0;
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {WIDTH{1'b0}};
        if (user_wr_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = wsel;
            wr_data_s = d;
        end else if (state_q == ST_SWEEP) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ptr_q;
            wr_data_s = {WIDTH{1'b0}};
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Sweep sequencer next-state; init is ignored once a sweep is running.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_SWEEP;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (ptr_q == LAST_PTR_C) begin
                    state_d = ST_IDLE;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    ptr_d   = ptr_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {AW{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
    end

    // Register array next-state and read-port data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_s && (wr_addr_s == AW'(i))) begin
                mem_d[i] = wr_data_s;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        q0_d = read_port(rsel0, wr_en_s, wr_addr_s, wr_data_s);
        q1_d = read_port(rsel1, wr_en_s, wr_addr_s, wr_data_s);
    end

    // State, storage and output registers; clr_n clears everything and aborts a sweep.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= {AW{1'b0}};
            busy_q  <= 1'b0;
            q0_q    <= {WIDTH{1'b0}};
            q1_q    <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign q0   = q0_q;
    assign q1   = q1_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_dual_rd.sv
// Scoreboard bench: two register files (8 deep with bypass, 5 deep without) share stimulus;
// a behavioural model predicts q0/q1/busy and a monitor compares after each edge.
module tb_regfile_dual_rd;

    logic       clk = 1'b0;
    logic       clr_n, en, init;
    logic [2:0] wsel, rsel0, rsel1;
    logic [7:0] d;
    logic [7:0] q0_a, q1_a, q0_b, q1_b;
    logic       busy_a, busy_b;

    always #5 clk = ~clk;

    regfile_dual_rd #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(1)) dut_a (
        .clk(clk), .clr_n(clr_n), .en(en), .wsel(wsel), .d(d),
        .rsel0(rsel0), .rsel1(rsel1), .init(init),
        .q0(q0_a), .q1(q1_a), .busy(busy_a));

    regfile_dual_rd #(.WIDTH(8), .DEPTH(5), .AW(3), .BYPASS(0)) dut_b (
        .clk(clk), .clr_n(clr_n), .en(en), .wsel(wsel), .d(d),
        .rsel0(rsel0), .rsel1(rsel1), .init(init),
        .q0(q0_b), .q1(q1_b), .busy(busy_b));

    typedef struct packed {
        logic [7:0] q0;
        logic [7:0] q1;
        logic       busy;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: plain arrays, a sweeping flag and a count of registers cleared so far.
    logic [7:0] m_mem [2][8];
    bit         m_sweep [2];
    int         m_idx [2];
    int         m_depth [2] = '{8, 5};
    bit         m_byp [2]   = '{1'b1, 1'b0};

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) m_mem[m][i] = 8'h00;
            m_sweep[m] = 1'b0;
            m_idx[m]   = 0;
        end
    endfunction

    function automatic logic [7:0] model_read(int m, int sel, bit act, int wa, logic [7:0] wd);
        if (sel >= m_depth[m]) return 8'h00;
        if (m_byp[m] && act && wa == sel) return wd;
        return m_mem[m][sel];
    endfunction

    function automatic exp_t model_step(int m);
        exp_t       e;
        bit         act;
        int         wa;
        logic [7:0] wd;
        act = 1'b0;
        wa  = 0;
        wd  = 8'h00;
        if (en && !m_sweep[m] && !init && int'(wsel) < m_depth[m]) begin
            act = 1'b1; wa = int'(wsel); wd = d;
        end else if (m_sweep[m]) begin
            act = 1'b1; wa = m_idx[m]; wd = 8'h00;
        end
        e.q0 = model_read(m, int'(rsel0), act, wa, wd);
        e.q1 = model_read(m, int'(rsel1), act, wa, wd);
        if (act) m_mem[m][wa] = wd;
        if (m_sweep[m]) begin
            m_idx[m]++;
            if (m_idx[m] == m_depth[m]) begin
                m_sweep[m] = 1'b0;
                m_idx[m]   = 0;
            end
        end else if (init) begin
            m_sweep[m] = 1'b1;
            m_idx[m]   = 0;
        end
        e.busy = m_sweep[m];
        return e;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    // Monitor: every output sample after an edge is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                chk("a.q0", q0_a, e.q0);
                chk("a.q1", q1_a, e.q1);
                chk("a.busy", {7'd0, busy_a}, {7'd0, e.busy});
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                chk("b.q0", q0_b, e.q0);
                chk("b.q1", q1_b, e.q1);
                chk("b.busy", {7'd0, busy_b}, {7'd0, e.busy});
            end
        end
    end

    task automatic step(input bit e_i, input logic [2:0] ws, input logic [7:0] dd,
                        input logic [2:0] r0, input logic [2:0] r1, input bit in_i);
        en = e_i; wsel = ws; d = dd; rsel0 = r0; rsel1 = r1; init = in_i;
        exp_a.push_back(model_step(0));
        exp_b.push_back(model_step(1));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        en    = 1'b0;
        init  = 1'b0;
        #1;
        chk("rst.a.q0", q0_a, 8'h00);
        chk("rst.a.q1", q1_a, 8'h00);
        chk("rst.a.busy", {7'd0, busy_a}, 8'h00);
        chk("rst.b.q0", q0_b, 8'h00);
        chk("rst.b.q1", q1_b, 8'h00);
        chk("rst.b.busy", {7'd0, busy_b}, 8'h00);
        exp_a.delete();
        exp_b.delete();
        model_reset();
        @(posedge clk);
        #2;
        clr_n = 1'b1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
    endtask

    initial begin
        clr_n = 1'b0; en = 1'b0; init = 1'b0;
        wsel = 3'd0; d = 8'h00; rsel0 = 3'd0; rsel1 = 3'd0;
        model_reset();
        @(posedge clk);
        #2;
        do_reset();

        // Write and dual read
        step(1'b1, 3'd0, 8'hAA, 3'd0, 3'd0, 1'b0);
        step(1'b1, 3'd1, 8'h55, 3'd0, 3'd0, 1'b0);
        step(1'b1, 3'd2, 8'hFF, 3'd0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);

        // Bypass versus pre-write read
        step(1'b1, 3'd3, 8'h3C, 3'd3, 3'd3, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0);

        // Load everything, then reset mid-cycle and read back zeros
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i), 3'd0, 1'b0);
        do_reset();
        read_all();

        // Sweep with a dropped write and init held across it
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(8'hA0 + i), 3'd0, 3'd7, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
        step(1'b1, 3'd5, 8'h77, 3'd5, 3'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 8'h00, 3'd5, 3'(i), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 8'h00, 3'd5, 3'd1, 1'b0);
        read_all();

        // Out-of-range address for the 5-deep instance
        step(1'b1, 3'd6, 8'h99, 3'd6, 3'd6, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 1'b0);
        read_all();

        // Write/init collision, then reset three cycles into the sweep
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(8'h30 + i), 3'd0, 3'd0, 1'b0);
        step(1'b1, 3'd2, 8'h42, 3'd2, 3'd2, 1'b1);
        step(1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 1'b0);
        do_reset();
        read_all();

        // Randomised traffic with occasional sweeps and resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 3'($urandom), 3'($urandom), ($urandom_range(0, 24) == 0));
        end
        step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);

        total_cnt++;
        if (exp_a.size() == 0 && exp_b.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_a.size(), exp_b.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_dual_rd.md
# regfile_dual_rd

Parametrised register file with a single write port and two registered read ports. Adds configurable width and depth, an optional write-to-read bypass, and a hardware-sequenced clear-all (sweep) FSM with a busy flag. Sits in the datapath lab designs as the general storage block for multi-operand units (e.g. ALU source A/B).

## Interface

- WIDTH, 8, data width in bits (≥1)
- DEPTH, 8, number of registers (2..256; need not be a power of two)
- AW, 3, address width; must satisfy 2^AW ≥ DEPTH
- BYPASS, 1, 1 = same-cycle write forwarded to read outputs; 0 = read returns pre-write contents

- clk  input  1  clock; all state changes on rising edge
- clr_n  input  1  reset, asynchronous, active-low
- en  input  1  write enable
- wsel  input  AW  write address
- d  input  WIDTH  write data
- rsel0  input  AW  read address, port 0
- rsel1  input  AW  read address, port 1
- init  input  1  start clear-all sweep (sampled only in IDLE)
- q0  output  WIDTH  read data, port 0 (registered)
- q1  output  WIDTH  read data, port 1 (registered)
- busy  output  1  high while sweep is running

## Operation

- Reset (clr_n=0, any time, independent of clk): all DEPTH registers = 0, q0 = q1 = 0, busy = 0, FSM = IDLE, sweep pointer = 0. Reset mid-sweep aborts the sweep.
- FSM states: IDLE, SWEEP.
  - IDLE → SWEEP on a rising edge with init=1. Pointer loads 0.
  - SWEEP: each edge writes 0 to reg[ptr], ptr++. After writing reg[DEPTH-1], → IDLE, ptr = 0.
  - init while in SWEEP: ignored (no restart).
- User write: at rising edge, if en=1, state=IDLE, init=0 and wsel < DEPTH, then reg[wsel] ← d.
  - wsel ≥ DEPTH: write dropped, no other register affected.
  - en=1 during SWEEP: write dropped (no queueing).
  - en=1 and init=1 in the same IDLE cycle: init wins, write dropped.
- Active write for the cycle is the user write if accepted, else the sweep write (address ptr, data 0) in SWEEP, else none.
- Read, per port k (independent, identical rules): at rising edge, qk ←
  - 0 if rselk ≥ DEPTH;
  - else if BYPASS=1 and an active write targets rselk this cycle: that write's data (d, or 0 for sweep);
  - else reg[rselk] as held before this edge.
- Both ports may address the same register, including the one being written; both obey the rule above.
- Registers not addressed by the active write hold their value.

## Timing

- Write latency: data written at edge N is visible in reg at N; read with rsel at cycle N+1 shows it at q after edge N+1 (BYPASS=0), or at q after edge N when rsel=wsel in cycle N (BYPASS=1).
- Read latency: 1 cycle, address presented before edge N, data valid on q after edge N, stable until the next edge.
- busy: rises after the edge sampling init=1, stays high exactly DEPTH cycles, falls after the edge that clears reg[DEPTH-1]. First user write accepted the cycle busy reads 0.
- clr_n deassertion: first state change on the first rising edge with clr_n=1; init sampled on that edge is honoured.

## Test plan

- Reset: clr_n=0 mid-cycle with registers loaded → q0=q1=0, busy=0 immediately; all registers read 0 after release.
- Write/dual read (WIDTH=8, DEPTH=8): write reg0=AA, reg1=55, reg2=FF; rsel0=1, rsel1=2 → q0=55, q1=FF one cycle later; rsel0=rsel1=0 → both AA.
- Bypass: en=1, wsel=3, d=3C, rsel0=3 in the same cycle → q0=3C after that edge with BYPASS=1; q0=previous reg3 (00) with BYPASS=0, then 3C next cycle.
- Sweep: load all 8 registers with non-zero values, pulse init → busy high exactly 8 cycles; en=1, wsel=5, d=77 during busy is dropped; afterwards all read 00; init held during SWEEP does not extend busy.
- Non-power-of-two (DEPTH=5, AW=3): write wsel=6, d=99 → no register changes; rsel0=6 → q0=00; sweep busy = 5 cycles.
- Collision/reset mid-sweep: en=1 and init=1 together → write dropped, sweep starts; clr_n=0 at sweep cycle 3 → busy=0 immediately, FSM IDLE, all registers 0.
